// File: rtl/core_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: ID forward selects,
// load-use / MDU interlocks, branch and exception/ERET flush, stall counter.
module core_hazard_ctrl #(
    parameter int MDU_LATENCY      = 32,
    parameter int EXC_FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rs,
    input  logic        ID_uses_rt,
    input  logic        ID_uses_mdu,
    input  logic [4:0]  EX_W_regnum,
    input  logic        EX_write_enable,
    input  logic        EX_mem_read,
    input  logic [4:0]  MEM_W_regnum,
    input  logic        MEM_write_enable,
    input  logic        mdu_start,
    input  logic        branch_taken,
    input  logic        exception,
    input  logic        eret,
    output logic [1:0]  forward_A,
    output logic [1:0]  forward_B,
    output logic        stall,
    output logic        flush_IF,
    output logic        flush_ID,
    output logic [1:0]  pc_redirect,
    output logic        mdu_busy,
    output logic [31:0] stall_count
);

    // state    | meaning
    // ST_RUN   | normal issue; branch/stall honoured, exception/ERET accepted
    // ST_FLUSH | post-exception drain; IF/ID and ID/EX held cleared
    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2
    } forward_type_t;

    localparam int MDU_W = $clog2(MDU_LATENCY + 1);
    localparam int EXC_W = (EXC_FLUSH_CYCLES > 1) ? $clog2(EXC_FLUSH_CYCLES) : 1;
    localparam logic [MDU_W-1:0] MDU_LOAD = MDU_W'(MDU_LATENCY);
    localparam logic [EXC_W-1:0] EXC_LOAD = EXC_W'(EXC_FLUSH_CYCLES - 1);

    state_t            state;
    logic [EXC_W-1:0]  exc_cnt;
    logic [MDU_W-1:0]  mdu_cnt;

    forward_type_t     fwd_rs;
    forward_type_t     fwd_rt;
    logic              load_use;
    logic              mdu_stall;
    logic              exc_req;
    logic              in_run;
    logic              accept;
    logic              branch_go;
    logic              stall_int;

    function automatic forward_type_t fwd_select(
        input logic [4:0] src,
        input logic       uses,
        input logic [4:0] ex_reg,
        input logic       ex_we,
        input logic       ex_load,
        input logic [4:0] mem_reg,
        input logic       mem_we
    );
        forward_type_t sel;
        sel = FWD_NONE;
        if (uses && src != 5'd0) begin
            if (ex_we && ex_reg == src && !ex_load)
                sel = FWD_EX;
            else if (mem_we && mem_reg == src)
                sel = FWD_MEM;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_rs = fwd_select(ID_rs, ID_uses_rs, EX_W_regnum, EX_write_enable,
                            EX_mem_read, MEM_W_regnum, MEM_write_enable);
        fwd_rt = fwd_select(ID_rt, ID_uses_rt, EX_W_regnum, EX_write_enable,
                            EX_mem_read, MEM_W_regnum, MEM_write_enable);
    end

    assign load_use  = EX_mem_read && (EX_W_regnum != 5'd0) &&
                       ((ID_uses_rs && ID_rs == EX_W_regnum) ||
                        (ID_uses_rt && ID_rt == EX_W_regnum));
    assign mdu_busy  = (mdu_cnt != '0);
    assign mdu_stall = mdu_busy && ID_uses_mdu;

    assign exc_req   = exception || eret;
    assign in_run    = (state == ST_RUN);
    assign accept    = in_run && exc_req;
    assign branch_go = in_run && branch_taken && !exc_req;
    assign stall_int = (load_use || mdu_stall) && in_run && !branch_taken && !exc_req;

    // Combinational controls are forced quiet while reset is held.
    always_comb begin
        forward_A   = 2'd0;
        forward_B   = 2'd0;
        stall       = 1'b0;
        flush_IF    = 1'b0;
        flush_ID    = 1'b0;
        pc_redirect = 2'd0;
        if (!reset) begin
            forward_A = fwd_rs;
            forward_B = fwd_rt;
            stall     = stall_int;
            flush_IF  = accept || !in_run || branch_go;
            flush_ID  = accept || !in_run || branch_go;
            if (accept)
                pc_redirect = 2'd2;
            else if (branch_go)
                pc_redirect = 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            exc_cnt     <= '0;
            mdu_cnt     <= '0;
            stall_count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (exc_req) begin
                        exc_cnt <= EXC_LOAD;
                        if (EXC_FLUSH_CYCLES > 1)
                            state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    exc_cnt <= exc_cnt - 1'b1;
                    // leave once the post-decrement value would read zero
                    if (exc_cnt == EXC_W'(1) || exc_cnt == '0)
                        state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase

            if (accept)
                mdu_cnt <= '0;
            else if (mdu_start)
                mdu_cnt <= MDU_LOAD;
            else if (mdu_cnt != '0)
                mdu_cnt <= mdu_cnt - 1'b1;

            if (stall_int && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Self-checking bench for core_hazard_ctrl: vector table plus multi-cycle
// MDU, branch, exception and mid-cycle reset sequences.
module tb_core_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_W_regnum, MEM_W_regnum;
    logic        ID_uses_rs, ID_uses_rt, ID_uses_mdu;
    logic        EX_write_enable, EX_mem_read, MEM_write_enable;
    logic        mdu_start, branch_taken, exception, eret;
    logic [1:0]  forward_A, forward_B, pc_redirect;
    logic        stall, flush_IF, flush_ID, mdu_busy;
    logic [31:0] stall_count;
    logic [9:0]  outs_act;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_sc = 32'd0;

    always #5 clock = ~clock;

    core_hazard_ctrl #(.MDU_LATENCY(4), .EXC_FLUSH_CYCLES(2)) dut (
        .clock(clock), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt), .ID_uses_mdu(ID_uses_mdu),
        .EX_W_regnum(EX_W_regnum), .EX_write_enable(EX_write_enable), .EX_mem_read(EX_mem_read),
        .MEM_W_regnum(MEM_W_regnum), .MEM_write_enable(MEM_write_enable),
        .mdu_start(mdu_start), .branch_taken(branch_taken), .exception(exception), .eret(eret),
        .forward_A(forward_A), .forward_B(forward_B), .stall(stall),
        .flush_IF(flush_IF), .flush_ID(flush_ID), .pc_redirect(pc_redirect),
        .mdu_busy(mdu_busy), .stall_count(stall_count)
    );

    assign outs_act = {forward_A, forward_B, stall, flush_IF, flush_ID, pc_redirect, mdu_busy};

    typedef struct {
        logic [4:0] rs;   logic [4:0] rt;
        logic urs;        logic urt;       logic umdu;
        logic [4:0] exw;  logic exwe;      logic exmr;
        logic [4:0] memw; logic memwe;
        logic mdus;       logic br;        logic exc;     logic er;
        logic [1:0] fa;   logic [1:0] fb;  logic st;      logic fif;   logic fid;
        logic [1:0] pcr;  logic busy;
    } vec_t;

    typedef struct {
        logic [9:0]  outs;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[15];

    function automatic vec_t mk(
        input int rs, input int rt, input int urs, input int urt, input int umdu,
        input int exw, input int exwe, input int exmr, input int memw, input int memwe,
        input int mdus, input int br, input int exc, input int er,
        input int fa, input int fb, input int st, input int fif, input int fid,
        input int pcr, input int busy);
        vec_t v;
        v.rs = 5'(rs);     v.rt = 5'(rt);
        v.urs = 1'(urs);   v.urt = 1'(urt);     v.umdu = 1'(umdu);
        v.exw = 5'(exw);   v.exwe = 1'(exwe);   v.exmr = 1'(exmr);
        v.memw = 5'(memw); v.memwe = 1'(memwe);
        v.mdus = 1'(mdus); v.br = 1'(br);       v.exc = 1'(exc);   v.er = 1'(er);
        v.fa = 2'(fa);     v.fb = 2'(fb);       v.st = 1'(st);
        v.fif = 1'(fif);   v.fid = 1'(fid);     v.pcr = 2'(pcr);   v.busy = 1'(busy);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", tag, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        ID_rs = v.rs; ID_rt = v.rt; ID_uses_rs = v.urs; ID_uses_rt = v.urt;
        ID_uses_mdu = v.umdu; EX_W_regnum = v.exw; EX_write_enable = v.exwe;
        EX_mem_read = v.exmr; MEM_W_regnum = v.memw; MEM_write_enable = v.memwe;
        mdu_start = v.mdus; branch_taken = v.br; exception = v.exc; eret = v.er;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {22'd0, outs_act}, {22'd0, e.outs});
            check({tag, "_stall_count"}, stall_count, e.sc);
        end
    endtask

    // One cycle: drive just after the edge, compare on the falling edge.
    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        @(posedge clock);
        #1;
        drive(v);
        e.outs = {v.fa, v.fb, v.st, v.fif, v.fid, v.pcr, v.busy};
        e.sc   = exp_sc;
        exp_q.push_back(e);
        if (v.st && exp_sc != 32'hFFFF_FFFF)
            exp_sc = exp_sc + 32'd1;
        @(negedge clock);
        compare(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rs rt us ut um exw we mr mw mwe ms br ex er  fa fb st fi fd pc bz
        tbl[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(5, 0, 1, 0, 0,  5, 1, 0,  0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 5, 0, 1, 0,  5, 1, 0,  5, 1,  0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(7, 0, 1, 0, 0,  3, 1, 0,  7, 1,  0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 1, 0,  0, 1, 0,  0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(5, 0, 0, 0, 0,  5, 1, 0,  5, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(8, 0, 1, 0, 0,  8, 1, 1,  0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 9, 0, 1, 0,  9, 1, 1,  9, 1,  0, 0, 0, 0,  0, 2, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 1, 0,  0, 1, 1,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(8, 8, 0, 0, 0,  8, 1, 1,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(8, 0, 1, 0, 0,  8, 1, 1,  0, 0,  0, 1, 0, 0,  0, 0, 0, 1, 1, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 0, 0,  0, 0, 0, 1, 1, 1, 0);
        tbl[12] = mk(4, 6, 1, 1, 0,  4, 1, 0,  6, 1,  0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0);
        tbl[13] = mk(4, 0, 1, 0, 0,  4, 0, 0,  4, 1,  0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

        // Reset: combinational controls must stay quiet even with a branch and a match present.
        reset = 1'b1;
        drive(mk(5, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        check("reset_outs", {22'd0, outs_act}, 32'd0);
        check("reset_stall_count", stall_count, 32'd0);
        drive(tbl[0]);
        #1 reset = 1'b0;

        for (int i = 0; i < 15; i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // Load-use: one bubble, then the load resolves from EX/MEM.
        apply("lu_stall", mk(8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        apply("lu_fwd",   mk(8, 0, 1, 0, 0, 3, 0, 0, 8, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));

        // MDU with the reader waiting: four stall cycles after the start.
        apply("mdu_start", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++)
            apply($sformatf("mdu_wait%0d", i), mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        apply("mdu_done", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // MDU busy but no reader: no stall.
        apply("mdu2_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++)
            apply($sformatf("mdu2_busy%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        apply("mdu2_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Restart while busy reloads the full latency.
        apply("mdu3_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("mdu3_busy",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        apply("mdu3_reld",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 1; i <= 4; i++)
            apply($sformatf("mdu3_after%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        apply("mdu3_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Exception clears the MDU interlock.
        apply("mdu4_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("mdu4_exc",   mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 2, 1));
        apply("mdu4_flush", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        apply("mdu4_run",   mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Exception + branch + load-use, repeated exception during FLUSH, then RUN.
        apply("exc_accept", mk(8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 2, 0));
        apply("exc_flush",  mk(8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        apply("exc_run_br", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        apply("eret_accept", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 2, 0));
        apply("eret_flush",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        apply("eret_run",    mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("eret_lu",     mk(8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // Async reset with the MDU counter at 3 and a reader stalled on it.
        apply("rm_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("rm_cnt4",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        apply("rm_cnt3",  mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        #1 reset = 1'b1;
        #1;
        check("rst_mdu_outs", {22'd0, outs_act}, 32'd0);
        check("rst_mdu_stall_count", stall_count, 32'd0);
        exp_sc = 32'd0;
        @(posedge clock);
        #3 reset = 1'b0;

        // Async reset in the FLUSH cycle, then RUN honours a branch.
        apply("rf_exc",   mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 2, 0));
        apply("rf_flush", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        #1 reset = 1'b1;
        #1;
        check("rst_flush_outs", {22'd0, outs_act}, 32'd0);
        check("rst_flush_stall_count", stall_count, 32'd0);
        @(posedge clock);
        #3 reset = 1'b0;
        apply("rf_run_br", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
